// File: rtl/dmem_responder_pkg.sv
// Shared types and widths for the data-memory responder.
// Optional statistics counters are enabled with DMEM_RESPONDER_STATS_EN.
package dmem_responder_pkg;

    localparam int DATA_W = 64;
    localparam int STRB_W = 8;
    localparam int ADDR_W = 64;
    localparam int STAT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_resp_array.sv
// DEPTH x 64-bit word storage for the data-memory responder.
// Byte-strobed synchronous write, combinational read on the same index.
module dmem_resp_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 128,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [IW-1:0]     i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Update only the enabled bytes of the addressed word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Target end of the CPU data-memory request interface with fixed latency.
// Define DMEM_RESPONDER_STATS_EN to add read/write/error completion counters.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [STRB_W-1:0] req_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o
`ifdef DMEM_RESPONDER_STATS_EN
    ,
    output logic [STAT_W-1:0] rd_cnt_o,
    output logic [STAT_W-1:0] wr_cnt_o,
    output logic [STAT_W-1:0] err_cnt_o
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_exec;
    logic              w_acc_write;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_wdata;
    logic [STRB_W-1:0] w_acc_wstrb;
    logic [IW-1:0]     w_idx;
    logic              w_err;
    logic              w_we;
    logic [DATA_W-1:0] w_mem_rdata;
    logic [DATA_W-1:0] w_rsp_rdata;

    assign w_accept = req_valid_i & r_req_ready;

    // With LATENCY==1 the access runs on the accept edge, straight from the inputs.
    assign w_exec = ((r_state == WAIT) && (r_cnt == '0))
                  | ((LATENCY == 1) && w_accept);

    assign w_acc_write = (r_state == IDLE) ? req_write_i : r_write;
    assign w_acc_addr  = (r_state == IDLE) ? req_addr_i  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? req_wdata_i : r_wdata;
    assign w_acc_wstrb = (r_state == IDLE) ? req_wstrb_i : r_wstrb;

    assign w_idx = w_acc_addr[3 +: IW];
    assign w_err = (|w_acc_addr[2:0]) | (|(w_acc_addr >> (3 + IW)));

    // Reset on the execute edge must suppress the write.
    assign w_we = w_exec & ~rst_i & w_acc_write & ~w_err;

    assign w_rsp_rdata = (w_err | w_acc_write) ? '0 : w_mem_rdata;

    dmem_resp_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .i_clk   (clk_i),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (w_acc_wdata),
        .i_wstrb (w_acc_wstrb),
        .o_rdata (w_mem_rdata)
    );

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write_i;
                        r_addr      <= req_addr_i;
                        r_wdata     <= req_wdata_i;
                        r_wstrb     <= req_wstrb_i;
                        r_req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rdata     <= w_rsp_rdata;
                            r_err       <= w_err;
                        end else begin
                            r_cnt   <= CNT_LOAD;
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= w_rsp_rdata;
                        r_err       <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rdata     <= '0;
                        r_err       <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

`ifdef DMEM_RESPONDER_STATS_EN
    logic [STAT_W-1:0] r_rd_cnt;
    logic [STAT_W-1:0] r_wr_cnt;
    logic [STAT_W-1:0] r_err_cnt;

    // Classify each completed response handshake into one saturating counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_err_cnt <= '0;
        end else if ((r_state == RESP) && rsp_ready_i) begin
            if (r_err) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end else if (r_write) begin
                r_wr_cnt <= sat_inc(r_wr_cnt);
            end else begin
                r_rd_cnt <= sat_inc(r_rd_cnt);
            end
        end
    end

    assign rd_cnt_o  = r_rd_cnt;
    assign wr_cnt_o  = r_wr_cnt;
    assign err_cnt_o = r_err_cnt;
`endif

endmodule
